// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, bubble encoding and control-bundle field offsets.
package pipe_pkg;

  localparam int DEF_CTRL_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  // An all-zero control bundle does nothing: no write, no memory access, no branch.
  localparam logic [DEF_CTRL_W-1:0] CTRL_BUBBLE = '0;

  localparam int CTRL_BRANCH     = 0;
  localparam int CTRL_MEMREAD    = 1;
  localparam int CTRL_MEMTOREG   = 2;
  localparam int CTRL_ALUOP_LSB  = 3;
  localparam int CTRL_ALUOP_W    = 4;
  localparam int CTRL_MEMWRITE   = 7;
  localparam int CTRL_ALUSRC     = 8;
  localparam int CTRL_REGWRITE   = 9;
  localparam int CTRL_UNCOND_JMP = 10;

endpackage

// File: rtl/fwd_select.sv
// Combinational priority matcher: picks the youngest forwarding port writing the given register.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int NFWD   = 2
) (
  input  logic [REG_AW-1:0]      addr,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD-1:0]        fwd_pending,
  input  logic [NFWD*REG_AW-1:0] fwd_rd,
  input  logic [NFWD*DATA_W-1:0] fwd_data,
  output logic                   hit,
  output logic [DATA_W-1:0]      data
);

  logic match;
  logic pend;

  // Scan oldest to youngest so the lowest matching index is the one left standing;
  // a pending youngest match blocks older ports rather than falling through.
  always_comb begin
    match = 1'b0;
    pend  = 1'b0;
    data  = '0;
    for (int j = NFWD - 1; j >= 0; j--) begin
      if (fwd_valid[j] && (fwd_rd[j*REG_AW +: REG_AW] == addr)) begin
        match = 1'b1;
        pend  = fwd_pending[j];
        data  = fwd_data[j*DATA_W +: DATA_W];
      end
    end
    hit = match && !pend && (addr != '0);
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid bit, stall hold, flush-to-bubble and
// operand refresh from forwarding ports while the held instruction waits.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W      = DEF_CTRL_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_AW      = DEF_REG_AW,
  parameter int NSRC        = 2,
  parameter int NFWD        = 2,
  parameter int STALL_CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [DATA_W-1:0]       in_pc,
  input  logic [DATA_W-1:0]       in_imme,
  input  logic [REG_AW-1:0]       in_rd,
  input  logic [NSRC*REG_AW-1:0]  in_src_addr,
  input  logic [NSRC*DATA_W-1:0]  in_src_data,
  input  logic [NFWD-1:0]         fwd_valid,
  input  logic [NFWD-1:0]         fwd_pending,
  input  logic [NFWD*REG_AW-1:0]  fwd_rd,
  input  logic [NFWD*DATA_W-1:0]  fwd_data,
  output logic                    out_valid,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [DATA_W-1:0]       out_pc,
  output logic [DATA_W-1:0]       out_imme,
  output logic [REG_AW-1:0]       out_rd,
  output logic [NSRC*REG_AW-1:0]  out_src_addr,
  output logic [NSRC*DATA_W-1:0]  out_src_data,
  output logic [NSRC-1:0]         out_src_fresh,
  output logic [STALL_CNT_W-1:0]  out_stall_cycles
);

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

  logic                   vld_p1;
  logic [CTRL_W-1:0]      ctrl_p1;
  logic [DATA_W-1:0]      pc_p1;
  logic [DATA_W-1:0]      imme_p1;
  logic [REG_AW-1:0]      rd_p1;
  logic [NSRC*REG_AW-1:0] src_addr_p1;
  logic [NSRC*DATA_W-1:0] src_data_p1;
  logic [NSRC-1:0]        fresh_p1;
  logic [STALL_CNT_W-1:0] stall_cnt_p1;

  logic [NSRC-1:0]        fwd_hit;
  logic [NSRC*DATA_W-1:0] fwd_val;

  // Matchers look at the held source addresses, since refresh only happens while holding.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_select #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .NFWD   (NFWD)
    ) u_fwd_select (
      .addr        (src_addr_p1[i*REG_AW +: REG_AW]),
      .fwd_valid   (fwd_valid),
      .fwd_pending (fwd_pending),
      .fwd_rd      (fwd_rd),
      .fwd_data    (fwd_data),
      .hit         (fwd_hit[i]),
      .data        (fwd_val[i*DATA_W +: DATA_W])
    );
  end

  // Stage p1 boundary: reset > flush > stall > load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      ctrl_p1      <= '0;
      pc_p1        <= '0;
      imme_p1      <= '0;
      rd_p1        <= '0;
      src_addr_p1  <= '0;
      src_data_p1  <= '0;
      fresh_p1     <= '0;
      stall_cnt_p1 <= '0;
    end else if (flush) begin
      vld_p1       <= 1'b0;
      ctrl_p1      <= CTRL_W'(CTRL_BUBBLE);
      fresh_p1     <= '0;
      stall_cnt_p1 <= '0;
    end else if (stall) begin
      if (vld_p1) begin
        stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        for (int i = 0; i < NSRC; i++) begin
          if (fwd_hit[i]) begin
            src_data_p1[i*DATA_W +: DATA_W] <= fwd_val[i*DATA_W +: DATA_W];
            fresh_p1[i]                     <= 1'b1;
          end
        end
      end
    end else begin
      vld_p1       <= in_valid;
      ctrl_p1      <= in_ctrl;
      pc_p1        <= in_pc;
      imme_p1      <= in_imme;
      rd_p1        <= in_rd;
      src_addr_p1  <= in_src_addr;
      src_data_p1  <= in_src_data;
      fresh_p1     <= '0;
      stall_cnt_p1 <= '0;
    end
  end

  assign out_valid        = vld_p1;
  assign out_ctrl         = ctrl_p1;
  assign out_pc           = pc_p1;
  assign out_imme         = imme_p1;
  assign out_rd           = rd_p1;
  assign out_src_addr     = src_addr_p1;
  assign out_src_data     = src_data_p1;
  assign out_src_fresh    = fresh_p1;
  assign out_stall_cycles = stall_cnt_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg against a behavioural reference model.
module tb_pipe_stage_reg;

  localparam int CTRL_W = 12;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NSRC   = 2;
  localparam int NFWD   = 2;
  localparam int SCW    = 4;
  localparam int SAT    = (1 << SCW) - 1;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   stall = 1'b0;
  logic                   flush = 1'b0;
  logic                   in_valid = 1'b0;
  logic [CTRL_W-1:0]      in_ctrl = '0;
  logic [DATA_W-1:0]      in_pc = '0;
  logic [DATA_W-1:0]      in_imme = '0;
  logic [REG_AW-1:0]      in_rd = '0;
  logic [NSRC*REG_AW-1:0] in_src_addr = '0;
  logic [NSRC*DATA_W-1:0] in_src_data = '0;
  logic [NFWD-1:0]        fwd_valid = '0;
  logic [NFWD-1:0]        fwd_pending = '0;
  logic [NFWD*REG_AW-1:0] fwd_rd = '0;
  logic [NFWD*DATA_W-1:0] fwd_data = '0;
  logic                   out_valid;
  logic [CTRL_W-1:0]      out_ctrl;
  logic [DATA_W-1:0]      out_pc;
  logic [DATA_W-1:0]      out_imme;
  logic [REG_AW-1:0]      out_rd;
  logic [NSRC*REG_AW-1:0] out_src_addr;
  logic [NSRC*DATA_W-1:0] out_src_data;
  logic [NSRC-1:0]        out_src_fresh;
  logic [SCW-1:0]         out_stall_cycles;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .REG_AW(REG_AW),
    .NSRC(NSRC), .NFWD(NFWD), .STALL_CNT_W(SCW)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_pc(in_pc), .in_imme(in_imme),
    .in_rd(in_rd), .in_src_addr(in_src_addr), .in_src_data(in_src_data),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ctrl(out_ctrl), .out_pc(out_pc), .out_imme(out_imme),
    .out_rd(out_rd), .out_src_addr(out_src_addr), .out_src_data(out_src_data),
    .out_src_fresh(out_src_fresh), .out_stall_cycles(out_stall_cycles)
  );

  // Reference state: one instruction slot plus its per-source operands.
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_pc, m_imme;
  logic [REG_AW-1:0] m_rd;
  logic [REG_AW-1:0] m_addr [NSRC];
  logic [DATA_W-1:0] m_data [NSRC];
  logic              m_fresh [NSRC];
  int                m_cnt;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_imme = '0; m_rd = '0; m_cnt = 0;
    for (int i = 0; i < NSRC; i++) begin
      m_addr[i] = '0; m_data[i] = '0; m_fresh[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [REG_AW-1:0] a;
    bit found;
    if (reset) begin
      m_clear();
    end else if (flush) begin
      m_valid = 1'b0; m_ctrl = '0; m_cnt = 0;
      for (int i = 0; i < NSRC; i++) m_fresh[i] = 1'b0;
    end else if (stall) begin
      if (m_valid) begin
        if (m_cnt < SAT) m_cnt = m_cnt + 1;
        for (int i = 0; i < NSRC; i++) begin
          a = m_addr[i];
          found = 1'b0;
          if (a != 0) begin
            for (int j = 0; j < NFWD; j++) begin
              if (!found && fwd_valid[j] && fwd_rd[j*REG_AW +: REG_AW] == a) begin
                found = 1'b1;
                if (!fwd_pending[j]) begin
                  m_data[i]  = fwd_data[j*DATA_W +: DATA_W];
                  m_fresh[i] = 1'b1;
                end
              end
            end
          end
        end
      end
    end else begin
      m_valid = in_valid; m_ctrl = in_ctrl; m_pc = in_pc; m_imme = in_imme; m_rd = in_rd;
      m_cnt = 0;
      for (int i = 0; i < NSRC; i++) begin
        m_addr[i]  = in_src_addr[i*REG_AW +: REG_AW];
        m_data[i]  = in_src_data[i*DATA_W +: DATA_W];
        m_fresh[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Outputs are compared against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 64'(out_valid), 64'(m_valid));
      chk("ctrl", 64'(out_ctrl), 64'(m_ctrl));
      chk("pc", 64'(out_pc), 64'(m_pc));
      chk("imme", 64'(out_imme), 64'(m_imme));
      chk("rd", 64'(out_rd), 64'(m_rd));
      chk("stall_cycles", 64'(out_stall_cycles), 64'(m_cnt));
      for (int i = 0; i < NSRC; i++) begin
        chk($sformatf("src_addr%0d", i), 64'(out_src_addr[i*REG_AW +: REG_AW]), 64'(m_addr[i]));
        chk($sformatf("src_data%0d", i), 64'(out_src_data[i*DATA_W +: DATA_W]), 64'(m_data[i]));
        chk($sformatf("fresh%0d", i), 64'(out_src_fresh[i]), 64'(m_fresh[i]));
      end
    end
  end

  task automatic load(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] pc,
                      input logic [REG_AW-1:0] a0, input logic [DATA_W-1:0] d0,
                      input logic [REG_AW-1:0] a1, input logic [DATA_W-1:0] d1);
    stall = 1'b0; flush = 1'b0; fwd_valid = '0; fwd_pending = '0;
    in_valid = v; in_ctrl = c; in_pc = pc; in_imme = pc + 32'h4; in_rd = 5'd3;
    in_src_addr = {a1, a0}; in_src_data = {d1, d0};
    tick();
  endtask

  task automatic set_fwd(input logic [1:0] v, input logic [1:0] p,
                         input logic [REG_AW-1:0] r0, input logic [DATA_W-1:0] d0,
                         input logic [REG_AW-1:0] r1, input logic [DATA_W-1:0] d1);
    fwd_valid = v; fwd_pending = p; fwd_rd = {r1, r0}; fwd_data = {d1, d0};
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: run exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    m_clear();
    tick();
    tick();
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_pc", 64'(out_pc), 64'd0);
    chk("reset_cnt", 64'(out_stall_cycles), 64'd0);
    chk("reset_src_data", 64'(out_src_data), 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Randomized traffic with a small register range to provoke forwarding hits.
    for (int n = 0; n < 600; n++) begin
      stall    = ($urandom_range(0, 99) < 50);
      flush    = ($urandom_range(0, 99) < 10);
      reset    = ($urandom_range(0, 99) < 2);
      in_valid = ($urandom_range(0, 99) < 80);
      in_ctrl  = CTRL_W'($urandom);
      in_pc    = $urandom;
      in_imme  = $urandom;
      in_rd    = REG_AW'($urandom_range(0, 31));
      for (int i = 0; i < NSRC; i++) begin
        in_src_addr[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
        in_src_data[i*DATA_W +: DATA_W] = $urandom;
      end
      for (int j = 0; j < NFWD; j++) begin
        fwd_valid[j]   = ($urandom_range(0, 99) < 70);
        fwd_pending[j] = ($urandom_range(0, 99) < 25);
        fwd_rd[j*REG_AW +: REG_AW]   = REG_AW'($urandom_range(0, 7));
        fwd_data[j*DATA_W +: DATA_W] = $urandom;
      end
      if (reset) m_clear();
      tick();
    end
    reset = 1'b0;

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    load(1'b1, 12'h001, 32'h40, 5'd1, 32'h11, 5'd2, 32'h22);
    chk("t1_pc_loaded", 64'(out_pc), 64'h40);
    #2;
    reset = 1'b1;
    m_clear();
    #1;
    chk("t1_async_valid", 64'(out_valid), 64'd0);
    chk("t1_async_pc", 64'(out_pc), 64'd0);
    tick();
    reset = 1'b0;

    // Load, stall three cycles, then flush overriding stall.
    load(1'b1, 12'h0A5, 32'h100, 5'd3, 32'h33, 5'd4, 32'h44);
    stall = 1'b1;
    tick(); tick(); tick();
    chk("t2_cnt3", 64'(out_stall_cycles), 64'd3);
    chk("t2_pc_hold", 64'(out_pc), 64'h100);
    chk("t2_ctrl_hold", 64'(out_ctrl), 64'h0A5);
    flush = 1'b1;
    tick();
    chk("t2_flush_valid", 64'(out_valid), 64'd0);
    chk("t2_flush_ctrl", 64'(out_ctrl), 64'd0);
    chk("t2_flush_cnt", 64'(out_stall_cycles), 64'd0);
    chk("t2_flush_pc", 64'(out_pc), 64'h100);

    // Youngest port wins; a pending youngest match blocks older ports.
    load(1'b1, 12'h003, 32'h200, 5'd5, 32'h1111, 5'd6, 32'h2222);
    stall = 1'b1;
    set_fwd(2'b11, 2'b00, 5'd5, 32'hAAAA, 5'd5, 32'hBBBB);
    tick();
    chk("t3_src0", 64'(out_src_data[31:0]), 64'hAAAA);
    chk("t3_src1", 64'(out_src_data[63:32]), 64'h2222);
    chk("t3_fresh", 64'(out_src_fresh), 64'b01);
    set_fwd(2'b11, 2'b01, 5'd5, 32'hCCCC, 5'd5, 32'hBBBB);
    tick();
    chk("t3_pending_hold", 64'(out_src_data[31:0]), 64'hAAAA);
    chk("t3_pending_fresh", 64'(out_src_fresh), 64'b01);

    // x0 is never refreshed; an invalid slot is never refreshed nor counted.
    load(1'b1, 12'h005, 32'h300, 5'd9, 32'h9999, 5'd0, 32'h5555);
    stall = 1'b1;
    set_fwd(2'b01, 2'b00, 5'd0, 32'hDEAD, 5'd0, 32'h0);
    tick();
    chk("t4_x0_hold", 64'(out_src_data[63:32]), 64'h5555);
    chk("t4_x0_fresh", 64'(out_src_fresh), 64'b00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_fwd(2'b01, 2'b00, 5'd9, 32'hBEEF, 5'd0, 32'h0);
    tick();
    chk("t4_invalid_hold", 64'(out_src_data[31:0]), 64'h9999);
    chk("t4_invalid_cnt", 64'(out_stall_cycles), 64'd0);

    // Load-use: pending on the first stall cycle, resolved by an older port on the second.
    load(1'b1, 12'h00B, 32'h400, 5'd7, 32'h0, 5'd0, 32'h0);
    stall = 1'b1;
    set_fwd(2'b01, 2'b01, 5'd7, 32'hFFFF, 5'd0, 32'h0);
    tick();
    chk("t5_c1_src0", 64'(out_src_data[31:0]), 64'h0);
    chk("t5_c1_fresh", 64'(out_src_fresh), 64'b00);
    set_fwd(2'b10, 2'b00, 5'd0, 32'h0, 5'd7, 32'h1234);
    tick();
    chk("t5_c2_src0", 64'(out_src_data[31:0]), 64'h1234);
    chk("t5_c2_fresh", 64'(out_src_fresh), 64'b01);
    load(1'b1, 12'h00C, 32'h404, 5'd1, 32'h1, 5'd2, 32'h2);
    chk("t5_load_fresh", 64'(out_src_fresh), 64'b00);

    // Saturating stall counter.
    stall = 1'b1;
    fwd_valid = '0;
    for (int k = 0; k < 20; k++) tick();
    chk("t6_sat", 64'(out_stall_cycles), 64'd15);

    stall = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
